// File: rtl/ethernet_mmio_pkg.sv
// Shared types for the MMIO-to-ethernet_controller adapter: controller address width,
// response struct declaration macro, and a modulo pointer-advance helper.
`ifndef ETHERNET_MMIO_PKG_GUARD
`define ETHERNET_MMIO_PKG_GUARD
`define DECLARE_ETH_MMIO_RESP_S(dw) typedef struct packed { logic [(dw)-1:0] data; logic err; } eth_mmio_resp_s
`endif

package ethernet_mmio_pkg;

    localparam int eth_ctrl_addr_width_gp = 14;

    // Advance a pointer by 0..2 slots in a ring of els entries (els need not be a power of two).
    function automatic int unsigned wrap_add(int unsigned ptr, int unsigned inc, int unsigned els);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= els) ? (sum - els) : sum;
    endfunction

endpackage

// File: rtl/ethernet_mmio_resp_fifo.sv
// Response FIFO with two enqueue ports (read-return slot ahead of request slot); registered outputs.
// Latency: enqueue to out_vld 1 cycle; backpressure: out_yumi dequeues, caller must never overfill.
module ethernet_mmio_resp_fifo
    import ethernet_mmio_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int els_p        = 2,
    localparam int width_lp       = data_width_p + 1,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      ret_vld,
    input  logic [width_lp-1:0]       ret_dat,
    input  logic                      req_vld,
    input  logic [width_lp-1:0]       req_dat,
    output logic                      out_vld,
    output logic [width_lp-1:0]       out_dat,
    input  logic                      out_yumi,
    output logic [count_width_lp-1:0] occupancy
);

    logic [width_lp-1:0]       mem_r [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_r;
    logic [ptr_width_lp-1:0]   rd_ptr_r;
    logic [count_width_lp-1:0] count_r;
    logic [ptr_width_lp-1:0]   wr_ptr_p1;
    logic [ptr_width_lp-1:0]   wr_ptr_next;
    logic [ptr_width_lp-1:0]   rd_ptr_p1;
    logic [ptr_width_lp-1:0]   req_slot;

    assign wr_ptr_p1   = ptr_width_lp'(wrap_add(32'(wr_ptr_r), 32'd1, els_p));
    assign wr_ptr_next = ptr_width_lp'(wrap_add(32'(wr_ptr_r), 32'(ret_vld) + 32'(req_vld), els_p));
    assign rd_ptr_p1   = ptr_width_lp'(wrap_add(32'(rd_ptr_r), 32'd1, els_p));
    // The read return belongs to an earlier acceptance, so it takes the older slot.
    assign req_slot    = ret_vld ? wr_ptr_p1 : wr_ptr_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (ret_vld) begin
                mem_r[wr_ptr_r] <= ret_dat;
            end
            if (req_vld) begin
                mem_r[req_slot] <= req_dat;
            end
            wr_ptr_r <= wr_ptr_next;
            if (out_yumi) begin
                rd_ptr_r <= rd_ptr_p1;
            end
            count_r <= count_r + count_width_lp'(ret_vld) + count_width_lp'(req_vld)
                     - count_width_lp'(out_yumi);
        end
    end

    assign out_vld   = (count_r != '0);
    assign out_dat   = out_vld ? mem_r[rd_ptr_r] : '0;
    assign occupancy = count_r;

endmodule

// File: rtl/ethernet_mmio_adapter.sv
// Valid/ready MMIO to ethernet_controller strobe adapter; ETHERNET_MMIO_ADAPTER_ERR_COUNT_EN adds a saturating error counter.
// Latency: write/error response 1 cycle, read response 2 cycles; backpressure: credits stop requests before the response FIFO can overflow.
module ethernet_mmio_adapter
    import ethernet_mmio_pkg::*;
#(
    parameter int                          data_width_p     = 32,
    parameter int                          req_addr_width_p = 20,
    parameter logic [req_addr_width_p-1:0] base_addr_p      = 20'h1_0000,
    parameter int                          resp_els_p       = 2,
    localparam int lg_data_bytes_lp = $clog2(data_width_p / 8),
    localparam int size_width_lp    = $clog2(lg_data_bytes_lp + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              req_v_i,
    output logic                              req_ready_and_o,
    input  logic                              req_we_i,
    input  logic [req_addr_width_p-1:0]       req_addr_i,
    input  logic [size_width_lp-1:0]          req_size_i,
    input  logic [data_width_p-1:0]           req_data_i,
    output logic                              resp_v_o,
    input  logic                              resp_ready_and_i,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              resp_err_o,
    output logic [15:0]                       err_count_o,
    output logic [eth_ctrl_addr_width_gp-1:0] addr_o,
    output logic                              write_en_o,
    output logic                              read_en_o,
    output logic [size_width_lp-1:0]          op_size_o,
    output logic [data_width_p-1:0]           write_data_o,
    input  logic [data_width_p-1:0]           read_data_i
);

    `DECLARE_ETH_MMIO_RESP_S(data_width_p);

    localparam int count_width_lp = $clog2(resp_els_p + 1);

    logic                        inflight_r;
    logic [count_width_lp-1:0]   occupancy;
    logic                        credit_ok;
    logic                        accept;
    logic                        hit;
    logic                        aligned;
    logic                        good;
    logic                        strobe;
    logic [req_addr_width_p-1:0] size_mask;
    eth_mmio_resp_s              ret_resp;
    eth_mmio_resp_s              req_resp;
    eth_mmio_resp_s              out_resp;

    // A read holds its credit while in flight, so the FIFO always has room for its return.
    assign credit_ok       = (32'(occupancy) + 32'(inflight_r)) < 32'(resp_els_p);
    assign req_ready_and_o = credit_ok & ~reset_i;
    assign accept          = req_v_i & req_ready_and_o;

    assign hit = req_addr_i[req_addr_width_p-1:eth_ctrl_addr_width_gp]
              == base_addr_p[req_addr_width_p-1:eth_ctrl_addr_width_gp];
    assign size_mask = (req_addr_width_p'(1) << req_size_i) - req_addr_width_p'(1);
    assign aligned   = (32'(req_size_i) <= 32'(lg_data_bytes_lp)) && ((req_addr_i & size_mask) == '0);
    assign good      = hit & aligned;

    assign write_en_o   = accept & good & req_we_i;
    assign read_en_o    = accept & good & ~req_we_i;
    assign strobe       = write_en_o | read_en_o;
    assign addr_o       = strobe ? req_addr_i[eth_ctrl_addr_width_gp-1:0] : '0;
    assign op_size_o    = strobe ? req_size_i : '0;
    assign write_data_o = strobe ? req_data_i : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= read_en_o;
        end
    end

    always_comb begin
        ret_resp      = '0;
        ret_resp.data = read_data_i;
        req_resp      = '0;
        req_resp.err  = ~good;
    end

    ethernet_mmio_resp_fifo #(
        .data_width_p (data_width_p),
        .els_p        (resp_els_p)
    ) resp_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .ret_vld   (inflight_r),
        .ret_dat   (ret_resp),
        .req_vld   (accept & ~read_en_o),
        .req_dat   (req_resp),
        .out_vld   (resp_v_o),
        .out_dat   (out_resp),
        .out_yumi  (resp_v_o & resp_ready_and_i),
        .occupancy (occupancy)
    );

    assign resp_data_o = out_resp.data;
    assign resp_err_o  = out_resp.err;

`ifdef ETHERNET_MMIO_ADAPTER_ERR_COUNT_EN
    logic [15:0] err_cnt_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_r <= '0;
        end else if (accept && !good && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign err_count_o = err_cnt_r;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_ethernet_mmio_adapter.sv
// Scoreboard bench for ethernet_mmio_adapter: requests push expected responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ethernet_mmio_adapter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_v;
    logic        req_rdy;
    logic        req_we;
    logic [19:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        resp_v;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [15:0] err_count;
    logic [13:0] addr;
    logic        write_en;
    logic        read_en;
    logic [1:0]  op_size;
    logic [31:0] write_data;
    logic [31:0] read_data;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_acc_cyc = 0;
    int   exp_err_cnt;

    ethernet_mmio_adapter dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .req_v_i          (req_v),
        .req_ready_and_o  (req_rdy),
        .req_we_i         (req_we),
        .req_addr_i       (req_addr),
        .req_size_i       (req_size),
        .req_data_i       (req_data),
        .resp_v_o         (resp_v),
        .resp_ready_and_i (resp_ready),
        .resp_data_o      (resp_data),
        .resp_err_o       (resp_err),
        .err_count_o      (err_count),
        .addr_o           (addr),
        .write_en_o       (write_en),
        .read_en_o        (read_en),
        .op_size_o        (op_size),
        .write_data_o     (write_data),
        .read_data_i      (read_data)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller storage model: one directed location, the rest derived from the address.
    function automatic logic [31:0] ctrl_mem(input logic [13:0] a);
        return (a == 14'h0004) ? 32'h1234_5678 : {18'h3_C0DE, a};
    endfunction

    // Controller sync read: data for a read strobe is presented during the following cycle.
    initial begin
        logic        pend;
        logic [13:0] pend_a;
        read_data = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk_i);
            #3;
            pend   = read_en;
            pend_a = addr;
            @(posedge clk_i);
            #1;
            read_data = pend ? ctrl_mem(pend_a) : 32'hBAD0_BAD0;
        end
    end

    // Response monitor: compares every consumed response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (!reset_i && resp_v && resp_ready) begin
                chk("resp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", resp_err, e.err);
                    if (e.lat != 0) chk("resp_lat", cyc - e.cyc, e.lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called right after a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic we, input logic [19:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input int lat);
        int   budget = 0;
        logic good;
        exp_t e;
        req_v = 1'b1; req_we = we; req_addr = a; req_size = sz; req_data = d;
        #1;
        while (!req_rdy && budget < 200) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        if (!req_rdy) begin
            chk("req_accept", req_rdy, 1);
        end else begin
            good = (a[19:14] == 6'h04) && (sz <= 2'd2) && ((a & ((20'd1 << sz) - 20'd1)) == 20'd0);
            chk("write_en", write_en, we & good);
            chk("read_en", read_en, !we & good);
            if (good) begin
                chk("addr", addr, a[13:0]);
                chk("op_size", op_size, sz);
            end
            if (good && we) chk("write_data", write_data, d);
            e.data = (good && !we) ? ctrl_mem(a[13:0]) : 32'h0;
            e.err  = !good;
            e.cyc  = cyc;
            e.lat  = lat;
            exp_q.push_back(e);
            last_acc_cyc = cyc;
        end
        @(negedge clk_i);
        req_v = 1'b0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req_rdy"}, req_rdy, 0);
        chk({pfx, "_resp_v"}, resp_v, 0);
        chk({pfx, "_resp_data"}, resp_data, 0);
        chk({pfx, "_resp_err"}, resp_err, 0);
        chk({pfx, "_write_en"}, write_en, 0);
        chk({pfx, "_read_en"}, read_en, 0);
        chk({pfx, "_addr"}, addr, 0);
        chk({pfx, "_op_size"}, op_size, 0);
        chk({pfx, "_write_data"}, write_data, 0);
        chk({pfx, "_err_count"}, err_count, 0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        @(negedge clk_i);
    endtask

    initial begin
        int c0;
        reset_i = 1'b1;
        resp_ready = 1'b1;
        req_v = 1'b1; req_we = 1'b1; req_addr = 20'h1_0010; req_size = 2'd2; req_data = 32'hDEAD_BEEF;
        #2;
        check_zero("rst");
        req_v = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rdy_after_rst", req_rdy, 1);
        @(negedge clk_i);

        // Directed write then read with latency checks.
        send(1'b1, 20'h1_0010, 2'd2, 32'hDEAD_BEEF, 1);
        repeat (3) @(negedge clk_i);
        send(1'b0, 20'h1_0004, 2'd2, 32'h0, 2);
        repeat (4) @(negedge clk_i);

        // Decode miss, misalignment, oversize.
        send(1'b0, 20'h2_0000, 2'd2, 32'h0, 1);
        send(1'b0, 20'h1_0002, 2'd2, 32'h0, 1);
`ifdef ETHERNET_MMIO_ADAPTER_ERR_COUNT_EN
        exp_err_cnt = 2;
`else
        exp_err_cnt = 0;
`endif
        chk("err_count_2", err_count, exp_err_cnt);
        send(1'b1, 20'h1_0000, 2'd3, 32'h5555_AAAA, 1);
`ifdef ETHERNET_MMIO_ADAPTER_ERR_COUNT_EN
        exp_err_cnt = 3;
`endif
        chk("err_count_3", err_count, exp_err_cnt);
        wait_drain("drain_err");

        // Response backpressure: two credits, third read waits for a dequeue.
        resp_ready = 1'b0;
        send(1'b0, 20'h1_0020, 2'd2, 32'h0, 0);
        send(1'b0, 20'h1_0024, 2'd1, 32'h0, 0);
        fork
            send(1'b0, 20'h1_0028, 2'd0, 32'h0, 0);
            begin
                repeat (3) @(negedge clk_i);
                #1;
                chk("full_hold", req_rdy, 0);
                resp_ready = 1'b1;
                @(negedge clk_i);
                #1;
                chk("credit_free", req_rdy, 1);
            end
        join
        wait_drain("drain_bp");

        // Alternating read/write with an always-ready response channel.
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 20'h1_0100 + 20'(8 * i), 2'd2, 32'h0, 0);
            c0 = last_acc_cyc;
            send(1'b1, 20'h1_0104 + 20'(8 * i), 2'd2, 32'h1111_0000 + 32'(i), 0);
            if (i == 0) chk("b2b_accept", last_acc_cyc - c0, 1);
        end
        wait_drain("drain_alt");

        // Asynchronous reset while a read is in flight.
        send(1'b0, 20'h1_0040, 2'd2, 32'h0, 0);
        #3;
        reset_i = 1'b1;
        req_v = 1'b1; req_we = 1'b1; req_addr = 20'h1_0010; req_size = 2'd2; req_data = 32'hFFFF_FFFF;
        #1;
        check_zero("mid_rst");
        exp_q.delete();
        req_v = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rdy_after_mid_rst", req_rdy, 1);
        repeat (5) @(negedge clk_i);
        chk("no_stale_resp", resp_v, 0);
        send(1'b0, 20'h1_0004, 2'd2, 32'h0, 2);
        wait_drain("drain_final");
        chk("err_count_final", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
